// File: rtl/aes_shiftrows_stage.sv
// Registered ShiftRows/InvShiftRows stage feeding MixColumn.
// The permuted state and its dec/last tags are buffered in a small FIFO ahead of the handshake.
module aes_shiftrows_stage #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_state,
  input  logic          in_dec,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_state,
  output logic          out_dec,
  output logic          mix_bypass,
  output logic [CW:0]   occupancy
);

  // Storage is sized to the full pointer range so every CW-bit index is in bounds;
  // pointers still wrap at DEPTH, so only the first DEPTH slots are ever used.
  localparam int unsigned SLOTS = 1 << CW;

  logic [127:0]  mem_state [SLOTS];
  logic          mem_dec   [SLOTS];
  logic          mem_last  [SLOTS];

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW:0]   count;
  logic [127:0]  perm_state;
  logic          push;
  logic          pop;

  function automatic logic [CW-1:0] next_ptr(input logic [CW-1:0] p);
    return (p == CW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic int unsigned src_col(input int unsigned c, input int unsigned r,
                                          input logic dec);
    return dec ? ((c + 4 - r) % 4) : ((c + r) % 4);
  endfunction

  // Byte A[k] sits at bits [127-8k -: 8]; row r, column c is A[4c+r].
  always_comb begin
    perm_state = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        perm_state[8*(15 - (4*c + r)) +: 8] =
          in_state[8*(15 - (4*src_col(c, r, in_dec) + r)) +: 8];
      end
    end
  end

  assign in_ready  = (count != (CW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign occupancy = count;

  assign out_state  = out_valid ? mem_state[rd_ptr] : '0;
  assign out_dec    = out_valid ? mem_dec[rd_ptr]   : 1'b0;
  assign mix_bypass = out_valid ? mem_last[rd_ptr]  : 1'b0;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_state[wr_ptr] <= perm_state;
      mem_dec[wr_ptr]   <= in_dec;
      mem_last[wr_ptr]  <= in_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
